// File: rtl/tonegen_multi.sv
// Purpose: multi-channel square-wave tone generator with timed notes and a PDM mixer.
// Latency: outputs registered; a write takes effect on its own edge, first toggle divider+1 edges later.
// Backpressure: none; every in-range config write is accepted immediately, out-of-range writes are dropped.
module tonegen_multi #(
  parameter int CHANNELS  = 4,
  parameter int DIV_WIDTH = 24,
  parameter int DUR_WIDTH = 24,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW = $clog2(2 * CHANNELS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_chan,
  input  logic [DIV_WIDTH-1:0] cfg_divider,
  input  logic [DUR_WIDTH-1:0] cfg_duration,
  output logic [CHANNELS-1:0]  chan_out,
  output logic [CHANNELS-1:0]  chan_active,
  output logic [CHANNELS-1:0]  done,
  output logic                 speaker
);

  logic [DIV_WIDTH-1:0] divider_q [CHANNELS];
  logic [DIV_WIDTH-1:0] divider_d [CHANNELS];
  logic [DIV_WIDTH-1:0] phase_q   [CHANNELS];
  logic [DIV_WIDTH-1:0] phase_d   [CHANNELS];
  logic [DUR_WIDTH-1:0] dur_q     [CHANNELS];
  logic [DUR_WIDTH-1:0] dur_d     [CHANNELS];
  logic [CHANNELS-1:0]  out_d;
  logic [CHANNELS-1:0]  done_d;
  logic [CHANNELS-1:0]  active_d;
  logic [CHANNELS-1:0]  wr_hit;

  logic [AW-1:0] acc_q;
  logic [AW-1:0] pop;
  logic [AW-1:0] mix_sum;

  // Decode the write strobe into a per-channel hit; indices past the last channel never match.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = cfg_we && (cfg_chan == CW'(i));
    end
  end

  // Per-channel next state: a write beats expiry, expiry beats a toggle.
  always_comb begin
    out_d    = chan_out;
    done_d   = '0;
    active_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      divider_d[i] = divider_q[i];
      phase_d[i]   = phase_q[i];
      dur_d[i]     = dur_q[i];
      if (wr_hit[i]) begin
        divider_d[i] = cfg_divider;
        dur_d[i]     = cfg_duration;
        phase_d[i]   = '0;
        out_d[i]     = 1'b0;
      end else if (divider_q[i] == '0) begin
        // Silent channel: hold the waveform low and freeze the duration counter.
        phase_d[i] = '0;
        out_d[i]   = 1'b0;
      end else if (dur_q[i] == DUR_WIDTH'(1)) begin
        // Last cycle of a timed note: stop everything and flag completion.
        divider_d[i] = '0;
        phase_d[i]   = '0;
        dur_d[i]     = '0;
        out_d[i]     = 1'b0;
        done_d[i]    = 1'b1;
      end else begin
        if (dur_q[i] != '0) begin
          dur_d[i] = dur_q[i] - DUR_WIDTH'(1);
        end
        if (phase_q[i] == divider_q[i]) begin
          out_d[i]   = ~chan_out[i];
          phase_d[i] = '0;
        end else begin
          phase_d[i] = phase_q[i] + DIV_WIDTH'(1);
        end
      end
      active_d[i] = (divider_d[i] != '0);
    end
  end

  // Channel state registers; reset silences every channel without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        divider_q[i] <= '0;
        phase_q[i]   <= '0;
        dur_q[i]     <= '0;
      end
      chan_out    <= '0;
      chan_active <= '0;
      done        <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        divider_q[i] <= divider_d[i];
        phase_q[i]   <= phase_d[i];
        dur_q[i]     <= dur_d[i];
      end
      chan_out    <= out_d;
      chan_active <= active_d;
      done        <= done_d;
    end
  end

  // Count how many channel outputs are high and add them to the running remainder.
  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop = pop + AW'(chan_out[i]);
    end
    mix_sum = acc_q + pop;
  end

  // First-order sigma-delta: emit a 1 each time the remainder crosses CHANNELS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      speaker <= 1'b0;
    end else if (mix_sum >= AW'(CHANNELS)) begin
      acc_q   <= mix_sum - AW'(CHANNELS);
      speaker <= 1'b1;
    end else begin
      acc_q   <= mix_sum;
      speaker <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tonegen_multi.sv
// Bench for tonegen_multi: directed scenarios plus random writes, checked against a
// closed-form model (each note described by write edge, divider and duration).
module tb_tonegen_multi;
  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_chan;
  logic [23:0] cfg_divider;
  logic [23:0] cfg_duration;
  logic [3:0]  chan_out, chan_active, done;
  logic        speaker;

  logic        cfg_we3;
  logic [1:0]  cfg_chan3;
  logic [7:0]  div3, dur3;
  logic [2:0]  out3, act3, done3;
  logic        spk3;

  always #5 clk = ~clk;

  tonegen_multi #(.CHANNELS(4), .DIV_WIDTH(24), .DUR_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_divider(cfg_divider), .cfg_duration(cfg_duration),
    .chan_out(chan_out), .chan_active(chan_active), .done(done), .speaker(speaker)
  );

  tonegen_multi #(.CHANNELS(3), .DIV_WIDTH(8), .DUR_WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we3), .cfg_chan(cfg_chan3),
    .cfg_divider(div3), .cfg_duration(dur3),
    .chan_out(out3), .chan_active(act3), .done(done3), .speaker(spk3)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a note is (write edge, divider, duration); outputs are computed from
  // the number of edges elapsed since the write.
  int m_div [C];
  int m_dur [C];
  int m_w   [C];
  int ecount;
  int tot;
  logic [3:0] e_out, e_act, e_done;
  logic       e_spk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void eval_model();
    int k;
    e_out = '0; e_act = '0; e_done = '0;
    for (int c = 0; c < C; c++) begin
      if (m_div[c] != 0) begin
        k = ecount - m_w[c];
        if (m_dur[c] != 0 && k >= m_dur[c]) begin
          e_done[c] = (k == m_dur[c]);
        end else begin
          e_act[c] = 1'b1;
          e_out[c] = ((k / (m_div[c] + 1)) % 2) == 1;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < C; c++) begin
      m_div[c] = 0; m_dur[c] = 0; m_w[c] = 0;
    end
    tot = 0;
    e_out = '0; e_act = '0; e_done = '0; e_spk = 1'b0;
  endfunction

  // One clock edge with an optional write; compares every main-DUT output afterwards.
  task automatic step(input bit we, input int ch, input int dv, input int du);
    int n, prev;
    cfg_we       = we;
    cfg_chan     = 2'(ch);
    cfg_divider  = 24'(dv);
    cfg_duration = 24'(du);
    n = $countones(e_out);
    @(posedge clk); #1;
    ecount++;
    if (we) begin
      m_div[ch] = dv; m_dur[ch] = du; m_w[ch] = ecount;
    end
    prev  = tot;
    tot   = tot + n;
    e_spk = (tot / C) != (prev / C);
    eval_model();
    check("chan_out",    {28'd0, chan_out},    {28'd0, e_out});
    check("chan_active", {28'd0, chan_active}, {28'd0, e_act});
    check("done",        {28'd0, done},        {28'd0, e_done});
    check("speaker",     {31'd0, speaker},     {31'd0, e_spk});
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int j = 0; j < cycles; j++) step(0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int act_cnt, done_cnt, spk_cnt, w_dv, w_du;
    rst = 1'b1; cfg_we = 1'b0; cfg_chan = '0; cfg_divider = '0; cfg_duration = '0;
    cfg_we3 = 1'b0; cfg_chan3 = '0; div3 = '0; dur3 = '0;
    ecount = 0;
    model_reset();

    // Reset state, with a write attempted during reset that must be ignored.
    repeat (2) @(posedge clk);
    #1;
    cfg_we = 1'b1; cfg_chan = 2'd0; cfg_divider = 24'd1; cfg_duration = 24'd0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("rst chan_out",    {28'd0, chan_out},    32'd0);
    check("rst chan_active", {28'd0, chan_active}, 32'd0);
    check("rst done",        {28'd0, done},        32'd0);
    check("rst speaker",     {31'd0, speaker},     32'd0);
    rst = 1'b0;

    // Three-channel instance: an index past the last channel changes nothing.
    cfg_we3 = 1'b1; cfg_chan3 = 2'd3; div3 = 8'd1; dur3 = 8'd5;
    @(posedge clk); #1;
    cfg_we3 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check("c3 bad idx out",  {29'd0, out3},  32'd0);
      check("c3 bad idx act",  {29'd0, act3},  32'd0);
      check("c3 bad idx done", {29'd0, done3}, 32'd0);
      check("c3 bad idx spk",  {31'd0, spk3},  32'd0);
      @(posedge clk); #1;
    end
    cfg_we3 = 1'b1; cfg_chan3 = 2'd2; div3 = 8'd1; dur3 = 8'd0;
    @(posedge clk); #1;
    cfg_we3 = 1'b0;
    check("c3 valid idx act", {29'd0, act3}, 32'd4);

    // Free-running tone on ch0, period 8.
    step(1, 0, 3, 0);
    idle(20);

    // Timed note on ch1: active exactly 10 cycles, one done pulse.
    act_cnt = 0; done_cnt = 0;
    step(1, 1, 1, 10);
    act_cnt += chan_active[1]; done_cnt += done[1];
    for (int j = 0; j < 12; j++) begin
      step(0, 0, 0, 0);
      act_cnt += chan_active[1]; done_cnt += done[1];
    end
    check("ch1 active cycles", act_cnt, 32'd10);
    check("ch1 done pulses",  done_cnt, 32'd1);
    check("ch1 out after",    {31'd0, chan_out[1]}, 32'd0);

    // Rewrite ch0 on its expiry edge: the new note wins and no done pulse appears.
    step(1, 0, 2, 6);
    idle(5);
    step(1, 0, 5, 0);
    check("ch0 rewrite no done", {31'd0, done[0]}, 32'd0);
    idle(26);

    // Silence via divider 0 produces no done pulse.
    step(1, 0, 0, 0);
    check("ch0 silence done", {31'd0, done[0]}, 32'd0);
    step(1, 1, 0, 0);

    // Mixer: all four outputs high -> speaker constantly high.
    for (int c = 0; c < C; c++) step(1, c, 50, 0);
    idle(51);
    spk_cnt = 0;
    for (int j = 0; j < 4 * C; j++) begin
      step(0, 0, 0, 0);
      spk_cnt += speaker;
    end
    check("mix all high", spk_cnt, 32'd16);
    // Two outputs high -> speaker high half the time.
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    spk_cnt = 0;
    for (int j = 0; j < 8; j++) begin
      step(0, 0, 0, 0);
      spk_cnt += speaker;
    end
    check("mix half", spk_cnt, 32'd4);

    // Reset in the middle of a timed note.
    step(1, 0, 2, 100);
    idle(20);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("midrst chan_out",    {28'd0, chan_out},    32'd0);
    check("midrst chan_active", {28'd0, chan_active}, 32'd0);
    check("midrst done",        {28'd0, done},        32'd0);
    check("midrst speaker",     {31'd0, speaker},     32'd0);
    cfg_we = 1'b1; cfg_chan = 2'd1; cfg_divider = 24'd3; cfg_duration = 24'd0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    ecount++;
    check("midrst write ignored", {28'd0, chan_active}, 32'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (int j = 0; j < 90; j++) begin
      step(0, 0, 0, 0);
      done_cnt += $countones(done);
    end
    check("no done after rst", done_cnt, 32'd0);
    step(1, 0, 1, 0);
    idle(6);

    // Random traffic against the model.
    for (int j = 0; j < 300; j++) begin
      w_dv = $urandom_range(0, 6);
      w_du = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3), w_dv, w_du);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
